// File: rtl/vcd4le_timer.sv
// vcd4le_timer: loadable down-counter timer with terminal count, optional
// auto-reload from a reload register, and a cascade-enable output.
// Q and BUSY are registered. TC and CEO are decoded combinationally from
// the current Q, state, ce and L.
module vcd4le_timer #(
   parameter int M = 4
) (
   input  logic         clk,
   input  logic         R_n,
   input  logic         ce,
   input  logic         L,
   input  logic         AR,
   input  logic [M-1:0] DI,
   output logic [M-1:0] Q,
   output logic         TC,
   output logic         CEO,
   output logic         BUSY
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [M-1:0] ONE = M'(1);

   state_t       state;
   logic [M-1:0] rld;
   logic         q_zero;

   assign q_zero = (Q == '0);

   // Terminal count comes straight from the count value, so it is also 1 in
   // IDLE/DONE where Q rests at 0.
   assign TC = q_zero;

   // A load in the terminal cycle wins over the cascade pulse.
   assign CEO = ce & TC & BUSY & ~L;

   // Timer FSM. A load restarts from any state. While running, each
   // ce-qualified cycle either decrements or, at zero, reloads (AR=1) or
   // parks in DONE. Zero is never decremented, so Q cannot wrap.
   always_ff @(posedge clk or negedge R_n) begin
      if (!R_n) begin
         state <= IDLE;
         Q     <= '0;
         rld   <= '0;
         BUSY  <= 1'b0;
      end else if (L) begin
         state <= RUN;
         Q     <= DI;
         rld   <= DI;
         BUSY  <= 1'b1;
      end else begin
         case (state)
            RUN: begin
               if (ce) begin
                  if (!q_zero) begin
                     Q <= Q - ONE;
                  end else if (AR) begin
                     Q <= rld;
                  end else begin
                     state <= DONE;
                     BUSY  <= 1'b0;
                  end
               end
            end
            IDLE, DONE: begin
               // Hold at rest. Q is already 0 here, because the only
               // entries into these states are reset and terminal count.
               BUSY <= 1'b0;
            end
            default: begin
               state <= IDLE;
               Q     <= '0;
               BUSY  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_vcd4le_timer.sv
// Bench for vcd4le_timer. A 4-bit instance covers the scenarios and random
// traffic. An 8-bit instance covers the full-range auto-reload period.
// Expected values come from rule-level reference variables kept here.
module tb_vcd4le_timer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       ce, l, ar;
   logic [3:0] di;
   logic [3:0] q;
   logic       tc, ceo, busy;

   logic       ce8, l8, ar8;
   logic [7:0] di8;
   logic [7:0] q8;
   logic       tc8, ceo8, busy8;

   int vec = 0;
   int err = 0;

   // Reference model for the 4-bit instance: remaining count, reload value,
   // and whether a countdown is in progress.
   int mq, mrld;
   bit mrun;

   always #5 clk = ~clk;

   vcd4le_timer #(.M(4)) dut (
      .clk(clk), .R_n(rst_n), .ce(ce), .L(l), .AR(ar), .DI(di),
      .Q(q), .TC(tc), .CEO(ceo), .BUSY(busy)
   );

   vcd4le_timer #(.M(8)) dut8 (
      .clk(clk), .R_n(rst_n), .ce(ce8), .L(l8), .AR(ar8), .DI(di8),
      .Q(q8), .TC(tc8), .CEO(ceo8), .BUSY(busy8)
   );

   task automatic model_reset();
      mq = 0; mrld = 0; mrun = 0;
   endtask

   // Applies the timer rules for one clock edge, using the inputs as driven.
   task automatic model_edge();
      if (l) begin
         mq = int'(di); mrld = int'(di); mrun = 1;
      end else if (mrun && ce) begin
         if (mq > 0) mq = mq - 1;
         else if (ar) mq = mrld;
         else mrun = 0;
      end
   endtask

   // Advance one clock and move the sampling point 1 time unit past the edge.
   task automatic tick();
      @(posedge clk); #1;
      model_edge();
   endtask

   task automatic test_reset();
      rst_n = 1'b0; ce = 1'b1; l = 1'b0; ar = 1'b0; di = 4'hA;
      ce8 = 1'b0; l8 = 1'b0; ar8 = 1'b0; di8 = 8'h00;
      #3;
      vec++; if (q !== 4'd0 || busy !== 1'b0 || tc !== 1'b1 || ceo !== 1'b0) begin
         err++; $display("FAIL reset_async: q=%0d busy=%b tc=%b ceo=%b want 0 0 1 0", q, busy, tc, ceo);
      end
      repeat (2) @(posedge clk);
      #1; rst_n = 1'b1; model_reset();
      for (int k = 0; k < 5; k++) begin
         ce = 1'b1; #1;
         vec++; if (q !== 4'd0 || busy !== 1'b0 || tc !== 1'b1 || ceo !== 1'b0) begin
            err++; $display("FAIL idle_after_reset c%0d: q=%0d busy=%b tc=%b ceo=%b want 0 0 1 0", k, q, busy, tc, ceo);
         end
         tick();
      end
   endtask

   task automatic test_oneshot();
      l = 1'b1; di = 4'd3; ar = 1'b0; ce = 1'b0; tick();
      l = 1'b0;
      for (int k = 0; k < 7; k++) begin
         ce = 1'b1; #1;
         vec++; if (q !== 4'((k < 3) ? 3 - k : 0)) begin
            err++; $display("FAIL oneshot_q c%0d: got %0d want %0d", k, q, (k < 3) ? 3 - k : 0);
         end
         vec++; if (ceo !== (k == 3)) begin
            err++; $display("FAIL oneshot_ceo c%0d: got %b want %b", k, ceo, k == 3);
         end
         vec++; if (busy !== (k <= 3)) begin
            err++; $display("FAIL oneshot_busy c%0d: got %b want %b", k, busy, k <= 3);
         end
         tick();
      end
   endtask

   task automatic test_autoreload();
      l = 1'b1; di = 4'd2; ar = 1'b1; ce = 1'b1; tick();
      l = 1'b0;
      for (int k = 0; k < 9; k++) begin
         ce = 1'b1; #1;
         vec++; if (q !== 4'(2 - (k % 3)) || busy !== 1'b1) begin
            err++; $display("FAIL reload_q c%0d: got %0d/%b want %0d/1", k, q, busy, 2 - (k % 3));
         end
         vec++; if (ceo !== ((k % 3) == 2)) begin
            err++; $display("FAIL reload_ceo c%0d: got %b want %b", k, ceo, (k % 3) == 2);
         end
         tick();
      end
      // Auto-reload off: the next terminal count ends the run in DONE.
      ar = 1'b0; ce = 1'b1;
      repeat (4) tick();
   endtask

   task automatic test_ce_toggle();
      l = 1'b1; di = 4'd4; ar = 1'b0; ce = 1'b0; tick();
      l = 1'b0;
      for (int k = 0; k < 14; k++) begin
         ce = (k % 2) == 0; #1;
         vec++; if (q !== 4'(mq) || busy !== mrun) begin
            err++; $display("FAIL toggle_q c%0d: got %0d/%b want %0d/%b", k, q, busy, mq, mrun);
         end
         vec++; if (ceo !== (ce && mrun && mq == 0)) begin
            err++; $display("FAIL toggle_ceo c%0d: got %b want %b", k, ceo, ce && mrun && mq == 0);
         end
         tick();
      end
   endtask

   task automatic test_load_at_tc();
      l = 1'b1; di = 4'd1; ar = 1'b0; ce = 1'b0; tick();
      l = 1'b0; ce = 1'b1; tick();
      // Now Q=0 in RUN: a terminal cycle, but with a simultaneous load.
      l = 1'b1; di = 4'd5; ce = 1'b1; #1;
      vec++; if (ceo !== 1'b0 || tc !== 1'b1 || q !== 4'd0) begin
         err++; $display("FAIL load_at_tc: ceo=%b tc=%b q=%0d want 0 1 0", ceo, tc, q);
      end
      tick();
      l = 1'b0;
      vec++; if (q !== 4'd5 || busy !== 1'b1) begin
         err++; $display("FAIL load_at_tc_next: q=%0d busy=%b want 5 1", q, busy);
      end
      repeat (3) tick();
      vec++; if (q !== 4'd2) begin
         err++; $display("FAIL pre_abort_q: got %0d want 2", q);
      end
      // Asynchronous reset mid-count, checked before any clock edge.
      rst_n = 1'b0; #1;
      vec++; if (q !== 4'd0 || busy !== 1'b0 || tc !== 1'b1 || ceo !== 1'b0) begin
         err++; $display("FAIL abort_async: q=%0d busy=%b tc=%b ceo=%b want 0 0 1 0", q, busy, tc, ceo);
      end
      model_reset();
      @(posedge clk); #1; rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         ce = 1'b1; #1;
         vec++; if (q !== 4'd0 || busy !== 1'b0 || ceo !== 1'b0) begin
            err++; $display("FAIL abort_idle c%0d: q=%0d busy=%b ceo=%b want 0 0 0", k, q, busy, ceo);
         end
         tick();
      end
   endtask

   task automatic test_random();
      for (int k = 0; k < 400; k++) begin
         l  = ($urandom_range(0, 7) == 0);
         ce = ($urandom_range(0, 3) != 0);
         ar = $urandom_range(0, 1) == 1;
         di = 4'($urandom_range(0, 15));
         #1;
         vec++; if (q !== 4'(mq) || busy !== mrun) begin
            err++; $display("FAIL rand_q c%0d: got %0d/%b want %0d/%b", k, q, busy, mq, mrun);
         end
         vec++; if (tc !== (mq == 0) || ceo !== (ce && !l && mrun && mq == 0)) begin
            err++; $display("FAIL rand_tc_ceo c%0d: got %b/%b want %b/%b", k, tc, ceo,
                            mq == 0, ce && !l && mrun && mq == 0);
         end
         tick();
      end
      l = 1'b0;
   endtask

   task automatic test_m8();
      int pulses = 0;
      l8 = 1'b1; di8 = 8'hFF; ar8 = 1'b1; ce8 = 1'b1;
      @(posedge clk); #1;
      l8 = 1'b0;
      for (int i = 1; i <= 520; i++) begin
         #1;
         vec++; if (q8 !== 8'(255 - ((i - 1) % 256)) || busy8 !== 1'b1) begin
            err++; $display("FAIL m8_q i%0d: got %0d/%b want %0d/1", i, q8, busy8, 255 - ((i - 1) % 256));
         end
         vec++; if (ceo8 !== ((i % 256) == 0)) begin
            err++; $display("FAIL m8_ceo i%0d: got %b want %b", i, ceo8, (i % 256) == 0);
         end
         if (ceo8 === 1'b1) pulses++;
         @(posedge clk); #1;
      end
      vec++; if (pulses != 2) begin
         err++; $display("FAIL m8_pulses: got %0d want 2", pulses);
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_oneshot();
      test_autoreload();
      test_ce_toggle();
      test_load_at_tc();
      test_random();
      test_m8();
      $display("== %0d vectors applied, %0d miscompares ==", vec, err);
      $finish;
   end

   // Absolute time limit so the run always ends on its own.
   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1);
   end

endmodule

// File: doc/vcd4le_timer.md
VCD4LE_TIMER -- requirements
Module: vcd4le_timer

Interface
REQ-001 SHALL have parameter M, default 4, counter and load-data width in bits (M >= 1).
REQ-002 SHALL have port clk, input, 1, single clock; all state changes on its rising edge.
REQ-003 SHALL have port R_n, input, 1, reset: asynchronous, active-low.
REQ-004 SHALL have port ce, input, 1, count enable; one decrement per cycle with ce=1 while running.
REQ-005 SHALL have port L, input, 1, synchronous load/start strobe.
REQ-006 SHALL have port AR, input, 1, auto-reload select, sampled live at the terminal cycle.
REQ-007 SHALL have port DI, input, M, load value for Q and the reload register.
REQ-008 SHALL have port Q, output, M, registered down-count value.
REQ-009 SHALL have port TC, output, 1, combinational terminal count, 1 when Q == 0.
REQ-010 SHALL have port CEO, output, 1, combinational cascade enable: ce & TC & BUSY & ~L.
REQ-011 SHALL have port BUSY, output, 1, registered; 1 only in state RUN.

Function
REQ-012 SHALL implement FSM states IDLE, RUN, DONE plus an internal M-bit reload register RLD.
REQ-013 L=1 (any state, any ce) SHALL set RLD<=DI, Q<=DI, state<=RUN at the next edge; L takes priority over counting.
REQ-014 In RUN with L=0, ce=1, Q != 0, Q SHALL decrement by 1 modulo nothing (no underflow path exists).
REQ-015 In RUN with L=0, ce=1, Q == 0: CEO SHALL be 1 that cycle; next edge Q<=RLD and stay RUN if AR=1, else Q stays 0 and state<=DONE.
REQ-016 In RUN with ce=0, Q and state SHALL hold; CEO=0.
REQ-017 In IDLE and DONE, ce SHALL be ignored, Q SHALL hold 0, CEO SHALL be 0; only L leaves these states.
REQ-018 Auto-reload period SHALL be RLD+1 ce-qualified cycles per CEO pulse; RLD=0 with AR=1 SHALL give CEO on every ce=1 cycle.
REQ-019 Load with DI=0 SHALL enter RUN with Q=0; the first subsequent ce=1 cycle SHALL be the terminal cycle.
REQ-020 L=1 coinciding with a terminal cycle SHALL suppress CEO and perform the load only.
REQ-021 Q SHALL never wrap from 0 to 2^M-1.
REQ-022 Output latency: Q and BUSY registered (1 cycle after the causing edge inputs); TC and CEO combinational from current Q, state, ce, L.

Reset
REQ-023 R_n=0 SHALL immediately (without clk) force Q=0, RLD=0, state IDLE, BUSY=0; hence TC=1, CEO=0.
REQ-024 Reset asserted mid-count SHALL abort the count; after release the block SHALL remain in IDLE until L.
REQ-025 Deassertion of R_n SHALL take effect at the first clk edge after release with no spurious count or CEO.

Verification
REQ-026 Reset release, ce=1 for 5 cycles, no L -> Q=0, BUSY=0, CEO=0 throughout, TC=1.
REQ-027 L with DI=3, AR=0, then ce=1 continuously -> Q 3,2,1,0; CEO=1 exactly in the Q=0 cycle; then DONE, BUSY=0, Q=0, CEO=0 for further ce.
REQ-028 L with DI=2, AR=1, ce=1 for 9 cycles -> Q 2,1,0,2,1,0,2,1,0; CEO pulses at cycles 3, 6, 9.
REQ-029 L with DI=4, ce toggling 1,0,1,0 -> Q decrements only on ce=1 cycles, holds on ce=0; CEO never asserted while ce=0 at Q=0.
REQ-030 RUN at Q=0, ce=1, L=1 with DI=5 in same cycle -> CEO=0, next Q=5, BUSY=1; also R_n pulsed low mid-count at Q=2 -> Q=0 immediately, IDLE.
REQ-031 M=8 instance: L with DI=0xFF, AR=1, ce=1 -> CEO every 256 cycles, Q never exceeds 0xFF, no wrap below 0.
